// File: rtl/bram_cart_x.sv
// bram_cart_x: byte-wide backup RAM cartridge on a 16-bit word SRAM.
// Write protect, async bus strobe sync, fixed-length write pulse, save request.
module bram_cart_x #(
    parameter int MEM_AW   = 18,
    parameter int ID_MIN   = 4,
    parameter int WE_LEN   = 8,
    parameter int SAVE_DLY = 5000000
) (
    input  logic              clk,
    input  logic              map_rst,
    input  logic [23:1]       cpu_addr,
    input  logic [15:0]       cpu_data,
    input  logic              cpu_oe,
    input  logic              cpu_we_lo,
    input  logic              cpu_ce_hi,
    input  logic              cart_on,
    input  logic              sst_act,
    input  logic [2:0]        size,
    output logic [15:0]       cart_dout,
    output logic              cart_oe,
    input  logic [15:0]       mem_dout,
    output logic [15:0]       mem_din,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_oe,
    output logic              mem_ce,
    output logic              mem_we_lo,
    output logic              mem_we_hi,
    output logic              wp_off,
    output logic              dirty,
    output logic              save_req,
    output logic              wr_drop,
    input  logic              save_ack
);
    localparam int CW = (SAVE_DLY > 1) ? $clog2(SAVE_DLY) : 1;

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        DIRTY = 2'd1,
        REQ   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          drop_q, drop_d;
    logic          wp_q, wp_d;
    logic          act_q, act_d;
    logic          lane_q, lane_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    dat_q, dat_d;
    logic [16:0]   wa_q, wa_d;
    logic [2:0]    rsy_q, rsy_d;
    logic [2:0]    gsy_q, gsy_d;

    logic [7:0]    id;
    logic [17:0]   ba_mask;
    logic [17:0]   ba;
    logic [16:0]   wa;
    logic          lane;
    logic          cart_ce, id_area, ram_area, reg_area;
    logic          ram_ev, reg_ev, acc;
    logic          unused;

    assign id = 8'(ID_MIN) + {5'd0, size};

    // Capacity is 8 KiB << id bytes; higher byte address bits alias.
    always_comb begin
        ba_mask = '1;
        for (int i = 0; i < 18; i++) begin
            if (i >= 13 + int'(id)) ba_mask[i] = 1'b0;
        end
    end

    assign ba   = cpu_addr[18:1] & ba_mask;
    assign wa   = ba[17:1];
    assign lane = ba[0];

    assign cart_ce  = cart_on & ~cpu_ce_hi;
    assign id_area  = cart_ce & (cpu_addr[23:20] == 4'h4);
    assign ram_area = cart_ce & (cpu_addr[23:20] == 4'h6);
    assign reg_area = cart_ce & (cpu_addr[23:20] == 4'h7);

    assign ram_ev = rsy_q[1] & ~rsy_q[2];
    assign reg_ev = gsy_q[1] & ~gsy_q[2];
    assign acc    = ram_ev & wp_q & ~sst_act & ~act_q;

    always_comb begin
        rsy_d  = {rsy_q[1:0], ram_area & ~cpu_we_lo};
        gsy_d  = {gsy_q[1:0], reg_area & ~cpu_we_lo};
        wp_d   = wp_q;
        drop_d = drop_q;
        act_d  = act_q;
        len_d  = len_q;
        wa_d   = wa_q;
        lane_d = lane_q;
        dat_d  = dat_q;
        if (reg_ev && !sst_act) wp_d = cpu_data[0];
        if (acc) begin
            act_d  = 1'b1;
            len_d  = 8'(WE_LEN);
            wa_d   = wa;
            lane_d = lane;
            dat_d  = cpu_data[7:0];
        end else if (act_q) begin
            if (len_q == 8'd1) act_d = 1'b0;
            len_d = len_q - 8'd1;
        end
        if (ram_ev && act_q && wp_q && !sst_act) drop_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        unique case (state_q)
            CLEAN: begin
                if (acc) begin
                    state_d = DIRTY;
                    cnt_d   = '0;
                end
            end
            DIRTY: begin
                if (acc) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(SAVE_DLY - 2)) state_d = REQ;
                end
            end
            REQ: begin
                if (acc) pend_d = 1'b1;
                if (save_ack) begin
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = (pend_q || acc) ? DIRTY : CLEAN;
                end
            end
            default: begin
                state_d = CLEAN;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (map_rst) begin
            state_q <= CLEAN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            drop_q  <= 1'b0;
            wp_q    <= 1'b0;
            act_q   <= 1'b0;
            lane_q  <= 1'b0;
            len_q   <= '0;
            dat_q   <= '0;
            wa_q    <= '0;
            rsy_q   <= '0;
            gsy_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            wp_q    <= wp_d;
            act_q   <= act_d;
            lane_q  <= lane_d;
            len_q   <= len_d;
            dat_q   <= dat_d;
            wa_q    <= wa_d;
            rsy_q   <= rsy_d;
            gsy_q   <= gsy_d;
        end
    end

    always_comb begin
        if (id_area) cart_dout = {id, id};
        else         cart_dout = {8'h00, lane ? mem_dout[15:8] : mem_dout[7:0]};
    end

    assign mem_oe    = ram_area & ~cpu_oe;
    assign mem_ce    = ram_area | act_q;
    assign cart_oe   = mem_oe | (id_area & ~cpu_oe);
    assign mem_we_lo = act_q & ~lane_q;
    assign mem_we_hi = act_q & lane_q;
    assign mem_din   = {dat_q, dat_q};
    assign mem_addr  = act_q ? MEM_AW'(wa_q) : MEM_AW'(wa);
    assign wp_off    = wp_q;
    assign dirty     = (state_q != CLEAN);
    assign save_req  = (state_q == REQ);
    assign wr_drop   = drop_q;
    assign unused    = ^{cpu_addr[19], cpu_data[15:8]};
endmodule

// File: tb/tb_bram_cart_x.sv
// Self-checking bench for bram_cart_x: read-path vector table, write/save
// sequences and randomized RAM traffic against a byte-array model.
module tb_bram_cart_x;
    localparam int MEM_AW   = 18;
    localparam int ID_MIN   = 4;
    localparam int WE_LEN   = 8;
    localparam int SAVE_DLY = 16;

    logic              clk;
    logic              map_rst;
    logic [23:1]       cpu_addr;
    logic [15:0]       cpu_data;
    logic              cpu_oe, cpu_we_lo, cpu_ce_hi;
    logic              cart_on, sst_act;
    logic [2:0]        size;
    logic [15:0]       cart_dout;
    logic              cart_oe;
    logic [15:0]       mem_dout, mem_din;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_oe, mem_ce, mem_we_lo, mem_we_hi;
    logic              wp_off, dirty, save_req, wr_drop, save_ack;

    bram_cart_x #(
        .MEM_AW(MEM_AW), .ID_MIN(ID_MIN),
        .WE_LEN(WE_LEN), .SAVE_DLY(SAVE_DLY)
    ) dut (
        .clk(clk), .map_rst(map_rst),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_oe(cpu_oe), .cpu_we_lo(cpu_we_lo), .cpu_ce_hi(cpu_ce_hi),
        .cart_on(cart_on), .sst_act(sst_act), .size(size),
        .cart_dout(cart_dout), .cart_oe(cart_oe),
        .mem_dout(mem_dout), .mem_din(mem_din), .mem_addr(mem_addr),
        .mem_oe(mem_oe), .mem_ce(mem_ce),
        .mem_we_lo(mem_we_lo), .mem_we_hi(mem_we_hi),
        .wp_off(wp_off), .dirty(dirty), .save_req(save_req),
        .wr_drop(wr_drop), .save_ack(save_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External SRAM model
    logic [15:0] mem [0:262143] = '{default: 16'h0000};
    logic [15:0] mem_rd, mem_force;
    logic        use_force;
    assign mem_rd   = mem[mem_addr];
    assign mem_dout = use_force ? mem_force : mem_rd;
    always @(posedge clk) begin
        if (mem_we_lo) mem[mem_addr][7:0]  <= mem_din[7:0];
        if (mem_we_hi) mem[mem_addr][15:8] <= mem_din[15:8];
    end

    int ntest = 0;
    int nfail = 0;
    int cyc = 0;
    int we_lo_n, we_hi_n, first_we, first_req, bad_pulse;
    logic [17:0] exp_ma;
    logic [15:0] exp_din;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clr_stats();
        we_lo_n = 0; we_hi_n = 0; first_we = -1; first_req = -1; bad_pulse = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mem_we_lo || mem_we_hi) begin
            if (first_we < 0) first_we = cyc;
            if (mem_addr !== exp_ma || mem_din !== exp_din) bad_pulse++;
        end
        if (mem_we_lo) we_lo_n++;
        if (mem_we_hi) we_hi_n++;
        if (save_req && first_req < 0) first_req = cyc;
    endtask

    task automatic bus_write(input logic [23:0] a, input logic [15:0] d, input int hold);
        cpu_addr = a[23:1];
        cpu_data = d;
        cpu_ce_hi = 1'b0;
        cpu_we_lo = 1'b0;
        repeat (hold) tick();
        cpu_we_lo = 1'b1;
        cpu_ce_hi = 1'b1;
    endtask

    task automatic bus_read(input logic [23:0] a);
        cpu_addr = a[23:1];
        cpu_ce_hi = 1'b0;
        cpu_oe = 1'b0;
        #1;
    endtask

    task automatic bus_idle();
        cpu_oe = 1'b1;
        cpu_ce_hi = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  sz;
        logic [23:0] a;
        logic        oe_n;
        logic        on;
        logic [15:0] md;
        logic [15:0] dout;
        logic        coe;
        logic        moe;
        logic        mce;
        logic [17:0] maddr;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_cyc;
        logic [7:0] refm [longint];
        logic wp_m;

        tbl[0]  = '{3'd1, 24'h400000, 1'b0, 1'b1, 16'h1234, 16'h0505, 1'b1, 1'b0, 1'b0, 18'h00000};
        tbl[1]  = '{3'd0, 24'h400000, 1'b0, 1'b1, 16'h1234, 16'h0404, 1'b1, 1'b0, 1'b0, 18'h00000};
        tbl[2]  = '{3'd0, 24'h400000, 1'b1, 1'b1, 16'h1234, 16'h0404, 1'b0, 1'b0, 1'b0, 18'h00000};
        tbl[3]  = '{3'd0, 24'h400000, 1'b0, 1'b0, 16'h1234, 16'h0034, 1'b0, 1'b0, 1'b0, 18'h00000};
        tbl[4]  = '{3'd0, 24'h600001, 1'b0, 1'b1, 16'hBEEF, 16'h00EF, 1'b1, 1'b1, 1'b1, 18'h00000};
        tbl[5]  = '{3'd0, 24'h600003, 1'b0, 1'b1, 16'hBEEF, 16'h00BE, 1'b1, 1'b1, 1'b1, 18'h00000};
        tbl[6]  = '{3'd0, 24'h67FFFF, 1'b0, 1'b1, 16'hBEEF, 16'h00BE, 1'b1, 1'b1, 1'b1, 18'h0FFFF};
        tbl[7]  = '{3'd1, 24'h67FFFF, 1'b0, 1'b1, 16'hBEEF, 16'h00BE, 1'b1, 1'b1, 1'b1, 18'h1FFFF};
        tbl[8]  = '{3'd2, 24'h67FFFF, 1'b0, 1'b1, 16'hBEEF, 16'h00BE, 1'b1, 1'b1, 1'b1, 18'h1FFFF};
        tbl[9]  = '{3'd0, 24'h640005, 1'b0, 1'b1, 16'h5A6B, 16'h006B, 1'b1, 1'b1, 1'b1, 18'h00001};
        tbl[10] = '{3'd0, 24'h700001, 1'b0, 1'b1, 16'h1234, 16'h0034, 1'b0, 1'b0, 1'b0, 18'h00000};
        tbl[11] = '{3'd3, 24'h4ABCDE, 1'b0, 1'b1, 16'h1234, 16'h0707, 1'b1, 1'b0, 1'b0, 18'h0AF37};
        tbl[12] = '{3'd0, 24'h600001, 1'b1, 1'b1, 16'hBEEF, 16'h00EF, 1'b0, 1'b0, 1'b1, 18'h00000};

        map_rst = 1'b1; cpu_addr = '0; cpu_data = '0;
        cpu_oe = 1'b1; cpu_we_lo = 1'b1; cpu_ce_hi = 1'b1;
        cart_on = 1'b1; sst_act = 1'b0; size = 3'd0; save_ack = 1'b0;
        use_force = 1'b0; mem_force = '0; exp_ma = '0; exp_din = '0;
        clr_stats();
        repeat (3) tick();
        map_rst = 1'b0;
        tick();
        chk("rst_wp_off", wp_off, 0);
        chk("rst_dirty", dirty, 0);
        chk("rst_save_req", save_req, 0);
        chk("rst_wr_drop", wr_drop, 0);
        chk("rst_mem_we", {mem_we_lo, mem_we_hi}, 0);

        use_force = 1'b1;
        for (int i = 0; i < 13; i++) begin
            size = tbl[i].sz;
            cpu_addr = tbl[i].a[23:1];
            cpu_oe = tbl[i].oe_n;
            cart_on = tbl[i].on;
            cpu_ce_hi = 1'b0;
            mem_force = tbl[i].md;
            #1;
            chk($sformatf("vec%0d {dout,coe,moe,mce,maddr}", i),
                {cart_dout, cart_oe, mem_oe, mem_ce, mem_addr},
                {tbl[i].dout, tbl[i].coe, tbl[i].moe, tbl[i].mce, tbl[i].maddr});
        end
        use_force = 1'b0; cart_on = 1'b1; size = 3'd0;
        bus_idle();
        tick();

        // Protected write is ignored, then unprotect and write lo lane
        clr_stats(); exp_ma = 18'h0; exp_din = 16'hA5A5;
        bus_write(24'h600001, 16'h00A5, 4);
        repeat (16) tick();
        chk("wp0_no_we", we_lo_n + we_hi_n, 0);
        chk("wp0_not_dirty", dirty, 0);
        bus_write(24'h700000, 16'h0001, 4);
        repeat (4) tick();
        chk("reg_wp_on", wp_off, 1);
        clr_stats();
        bus_write(24'h600001, 16'h00A5, 4);
        repeat (30) tick();
        chk("lo_pulse_len", we_lo_n, WE_LEN);
        chk("lo_no_hi", we_hi_n, 0);
        chk("lo_pulse_addr_din", bad_pulse, 0);
        chk("lo_dirty", dirty, 1);
        chk("save_req_latency", first_req - (first_we - 1), 16);
        chk("save_req_held", save_req, 1);
        save_ack = 1'b1; tick(); save_ack = 1'b0; tick();
        chk("ack_clean", {dirty, save_req}, 2'b00);

        // Hi lane write, readback, write during REQ
        clr_stats(); exp_ma = 18'h0; exp_din = 16'hA5A5;
        bus_write(24'h600003, 16'h00A5, 4);
        repeat (30) tick();
        chk("hi_pulse_len", we_hi_n, WE_LEN);
        chk("hi_no_lo", we_lo_n, 0);
        chk("hi_pulse_addr_din", bad_pulse, 0);
        bus_read(24'h600003);
        chk("readback_hi", cart_dout, 16'h00A5);
        bus_idle();
        chk("req_again", save_req, 1);
        clr_stats(); exp_ma = 18'h4; exp_din = 16'h3C3C;
        bus_write(24'h600011, 16'h003C, 4);
        repeat (12) tick();
        chk("req_write_pulse", we_lo_n, WE_LEN);
        chk("req_held_no_ack", save_req, 1);
        save_ack = 1'b1; ack_cyc = cyc; tick(); save_ack = 1'b0;
        chk("pend_ack_dirty", {dirty, save_req}, 2'b10);
        first_req = -1;
        repeat (24) tick();
        chk("pend_req_latency", first_req - ack_cyc, 16);
        save_ack = 1'b1; tick(); save_ack = 1'b0; tick();
        chk("ack2_clean", dirty, 0);

        // Two write edges 3 cycles apart: second dropped
        clr_stats(); exp_ma = 18'h8; exp_din = 16'h1111;
        cpu_addr = 23'h300010; cpu_data = 16'h0011;
        cpu_ce_hi = 1'b0; cpu_we_lo = 1'b0; tick();
        cpu_we_lo = 1'b1; tick(); tick();
        cpu_data = 16'h0022; cpu_we_lo = 1'b0; tick();
        cpu_we_lo = 1'b1; cpu_ce_hi = 1'b1;
        repeat (20) tick();
        chk("drop_one_pulse", we_lo_n, WE_LEN);
        chk("drop_first_data", bad_pulse, 0);
        chk("drop_flag", wr_drop, 1);
        bus_read(24'h600021);
        chk("drop_readback", cart_dout, 16'h0011);
        bus_idle();
        map_rst = 1'b1; tick(); tick(); map_rst = 1'b0; tick();
        chk("rst2_flags", {wr_drop, wp_off, dirty}, 3'b000);

        // Savestate activity blocks writes
        bus_write(24'h700000, 16'h0001, 4);
        repeat (4) tick();
        chk("reg_wp_on2", wp_off, 1);
        sst_act = 1'b1; clr_stats();
        bus_write(24'h600041, 16'h0077, 4);
        repeat (14) tick();
        chk("sst_no_we", we_lo_n + we_hi_n, 0);
        chk("sst_not_dirty", dirty, 0);
        bus_write(24'h700000, 16'h0000, 4);
        repeat (4) tick();
        chk("sst_wp_kept", wp_off, 1);
        sst_act = 1'b0;

        // Randomized traffic against a byte-addressed capacity model
        save_ack = 1'b1;
        wp_m = 1'b1;
        for (int n = 0; n < 60; n++) begin
            int op;
            logic [17:0] ba;
            logic [23:0] a;
            logic [7:0]  d;
            longint cap, key;
            op = $urandom_range(0, 9);
            size = 3'($urandom_range(0, 3));
            ba = {2'($urandom_range(0, 3)), 13'd0, 3'($urandom_range(2, 7))};
            a = 24'h600001 | (24'(ba) << 1);
            cap = 64'd8192 << (ID_MIN + int'(size));
            key = longint'(ba) % cap;
            if (op <= 5) begin
                d = 8'($urandom);
                bus_write(a, {8'($urandom), d}, 4);
                repeat (12) tick();
                if (wp_m) refm[key] = d;
            end else if (op <= 8) begin
                bus_read(a);
                chk($sformatf("rnd_read ba=0x%0h sz=%0d", ba, size),
                    {cart_oe, cart_dout},
                    {1'b1, 8'h00, refm.exists(key) ? refm[key] : 8'h00});
                bus_idle();
                tick();
            end else begin
                d = 8'($urandom_range(0, 1));
                bus_write(24'h700000, {8'h00, d}, 4);
                repeat (3) tick();
                wp_m = d[0];
                chk("rnd_wp", wp_off, wp_m);
            end
        end
        save_ack = 1'b0;
        chk("rnd_no_drop", wr_drop, 0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule

// File: doc/bram_cart_x.md
BRAM_CART_X -- requirements
Module: bram_cart_x

Interface
REQ-001 SHALL have parameter MEM_AW, default 18, meaning the 16-bit memory word address width.
REQ-002 SHALL have parameter ID_MIN, default 4, meaning the ID code returned when size=0.
REQ-003 SHALL have parameter WE_LEN, default 8, meaning the memory write strobe length in clk cycles (range 1..255).
REQ-004 SHALL have parameter SAVE_DLY, default 5000000, meaning the idle clk cycles after the last write before save_req (>=2).
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state is on its rising edge.
REQ-006 SHALL have port map_rst, input, 1 bit, the reset: synchronous and active-high.
REQ-007 SHALL have ports cpu_addr[23:1], cpu_data[15:0], cpu_oe, cpu_we_lo and cpu_ce_hi, all inputs; the strobes are active-low and asynchronous to clk.
REQ-008 SHALL have ports cart_on (1) and sst_act (1) as inputs, and size (3) as a static input selecting capacity.
REQ-009 SHALL have outputs cart_dout[15:0] and cart_oe.
REQ-010 SHALL have memory ports mem_dout[15:0] (input), and mem_din[15:0], mem_addr[MEM_AW-1:0], mem_oe, mem_ce, mem_we_lo and mem_we_hi (outputs).
REQ-011 SHALL have status outputs wp_off (1), dirty (1), save_req (1) and wr_drop (1), plus input save_ack (1).

Function
REQ-012 Decode: cart_ce = cart_on & !cpu_ce_hi; ID area is cpu_addr[23:20]=4'h4, RAM area is 4'h6, REG area is 4'h7, each qualified by cart_ce.
REQ-013 Capacity: id = ID_MIN+size, giving a byte capacity of 8 KiB << id; ba = cpu_addr[18:1] masked to that capacity, with wrap-around above it.
REQ-014 Packing: word address = ba>>1, lane = ba[0] (0 = lo byte, 1 = hi byte); mem_addr is zero-extended to MEM_AW.
REQ-015 Read path is combinational: mem_oe = RAM area & !cpu_oe; mem_ce = RAM area | write pulse active.
REQ-016 Read data: cart_dout = {8'h00, selected lane byte of mem_dout}; in the ID area cart_dout = {id,id}; cart_oe = mem_oe | (ID area & !cpu_oe).
REQ-017 Sync: the RAM-write condition (RAM area & !cpu_we_lo) and the REG-write condition SHALL each pass a 2-flop synchroniser followed by rising-edge detect, producing 1-cycle events.
REQ-018 A RAM write event SHALL be accepted only if wp_off=1, sst_act=0 and no pulse is active; on acceptance the word address, lane and cpu_data[7:0] are latched.
REQ-019 Write pulse: starting the cycle after acceptance, the lane's mem_we_lo/hi is high for exactly WE_LEN cycles; mem_din = {d,d}; mem_addr = latched address throughout; otherwise mem_addr = live decode.
REQ-020 A RAM write event arriving while a pulse is active SHALL be dropped and set the sticky wr_drop flag; events blocked by wp_off=0 or sst_act=1 SHALL be ignored silently.
REQ-021 A REG write event with sst_act=0 SHALL load wp_off <= cpu_data[0] on the cycle after the event.
REQ-022 Save FSM states: CLEAN, DIRTY, REQ; dirty = (state != CLEAN); save_req = (state == REQ).
REQ-023 CLEAN -> DIRTY on an accepted write, which also clears the idle counter.
REQ-024 In DIRTY, the idle counter increments each cycle and clears on an accepted write; the FSM moves DIRTY -> REQ when the count reaches SAVE_DLY-1.
REQ-025 In REQ, save_req holds until save_ack=1; an accepted write while in REQ sets a pending bit.
REQ-026 On save_ack in REQ: go to DIRTY with the counter cleared if pending (or a write is accepted that same cycle), else go to CLEAN; save_ack outside REQ is ignored.
REQ-027 The idle counter width is clog2(SAVE_DLY) and it SHALL NOT wrap while in DIRTY.

Reset
REQ-028 While map_rst=1 at a clk edge: wp_off=0, state=CLEAN, counter=0, pending=0, wr_drop=0, pulse inactive, synchroniser flops=0.
REQ-029 Outputs after reset: mem_we_lo=mem_we_hi=0, save_req=0, dirty=0; combinational outputs follow the inputs.
REQ-030 Reset mid-pulse SHALL deassert the strobes at the next edge with no partial completion.

Verification
REQ-031 size=1, ID_MIN=4, read 0x400000 -> cart_dout=16'h0505 and cart_oe=1; with size=0 -> 16'h0404.
REQ-032 wp_off=0, write 0xA5 to 0x600001 -> no mem_we; then reg write data=1, repeat -> mem_we_lo high for WE_LEN cycles, mem_addr=0, mem_din=16'hA5A5.
REQ-033 Write to 0x600003 (ba=1) -> mem_we_hi, word address 0; readback of 0x600003 -> cart_dout=16'h00A5.
REQ-034 SAVE_DLY=16, single write -> dirty=1, save_req rises 16 cycles after acceptance; ack -> CLEAN; write during REQ then ack -> DIRTY, and save_req recurs after 16 more idle cycles.
REQ-035 Two write edges 3 cycles apart with WE_LEN=8 -> first written, second dropped, wr_drop=1; map_rst -> wr_drop=0 and wp_off=0.
REQ-036 sst_act=1 during RAM and REG writes -> no mem_we, wp_off unchanged, dirty unchanged.
